// File: rtl/cyclic_prefix_inserter.sv
// Cyclic-prefix inserter: captures one N_FFT-sample symbol per ping-pong bank and
// replays it with its last CP_LEN samples prepended, back-to-back when possible.
module cyclic_prefix_inserter #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int N_FFT        = 8,
  parameter int CP_LEN       = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic signed [SAMPLE_WIDTH-1:0] in_sample,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic signed [SAMPLE_WIDTH-1:0] out_sample,
  output logic                           out_sop,
  output logic                           out_eop
);

  localparam int CW = $clog2(N_FFT);
  localparam logic [CW-1:0] LAST    = CW'(N_FFT - 1);
  localparam logic [CW-1:0] CP_BASE = CW'(N_FFT - CP_LEN);
  localparam logic [CW-1:0] CP_LAST = CW'(CP_LEN - 1);

  typedef enum logic [1:0] {IDLE, PREFIX, BODY} rd_state_e;

  // Handshake: a sample moves on a rising edge where in_valid && in_ready; in_ready
  // depends only on registered bank flags, never on in_valid. Output has no backpressure.
  logic signed [SAMPLE_WIDTH-1:0] bank_mem [2][N_FFT];

  logic [CW-1:0]                  wptr_q, wptr_d, rcnt_q, rcnt_d, rd_addr;
  logic                           wsel_q, wsel_d, rsel_q, rsel_d;
  logic [1:0]                     full_q, full_d;
  rd_state_e                      state_q, state_d;
  logic                           out_valid_q, out_valid_d;
  logic                           out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic signed [SAMPLE_WIDTH-1:0] out_sample_q, out_sample_d;
  logic                           wr_en, emit;

  assign in_ready = !full_q[wsel_q];
  assign wr_en    = in_valid && in_ready;

  always_comb begin
    wptr_d       = wptr_q;
    wsel_d       = wsel_q;
    full_d       = full_q;
    state_d      = state_q;
    rsel_d       = rsel_q;
    rcnt_d       = rcnt_q;
    rd_addr      = rcnt_q;
    emit         = 1'b0;
    out_sop_d    = 1'b0;
    out_eop_d    = 1'b0;

    if (wr_en) begin
      if (wptr_q == LAST) begin
        wptr_d         = '0;
        full_d[wsel_q] = 1'b1;
        wsel_d         = ~wsel_q;
      end else begin
        wptr_d = wptr_q + CW'(1);
      end
    end

    // The state names the phase of the sample being launched on this edge; a
    // release returns to IDLE, which launches the other bank's prefix on the very
    // next edge when it is already full, so symbols stay contiguous.
    case (state_q)
      IDLE: begin
        if (full_q[rsel_q]) begin
          emit      = 1'b1;
          rd_addr   = CP_BASE;
          out_sop_d = 1'b1;
          rcnt_d    = (CP_LEN == 1) ? '0 : CW'(1);
          state_d   = (CP_LEN == 1) ? BODY : PREFIX;
        end
      end
      PREFIX: begin
        emit    = 1'b1;
        rd_addr = CP_BASE + rcnt_q;
        if (rcnt_q == CP_LAST) begin
          rcnt_d  = '0;
          state_d = BODY;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      BODY: begin
        emit = 1'b1;
        if (rcnt_q == LAST) begin
          out_eop_d      = 1'b1;
          full_d[rsel_q] = 1'b0;
          rsel_d         = ~rsel_q;
          rcnt_d         = '0;
          state_d        = IDLE;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d  = emit;
    out_sample_d = emit ? bank_mem[rsel_q][rd_addr] : out_sample_q;
  end

  // Sample storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) bank_mem[wsel_q][wptr_q] <= in_sample;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      wsel_q       <= 1'b0;
      full_q       <= 2'b00;
      state_q      <= IDLE;
      rsel_q       <= 1'b0;
      rcnt_q       <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      wsel_q       <= wsel_d;
      full_q       <= full_d;
      state_q      <= state_d;
      rsel_q       <= rsel_d;
      rcnt_q       <= rcnt_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;

endmodule
